// File: rtl/disc_stream_scorer_pkg.sv
// Shared constants, state type and fixed-point helpers
// for the streaming 9-3-1 discriminator scorer.
package disc_stream_scorer_pkg;

  localparam int WIDTH = 32;
  localparam int FRAC  = 16;
  localparam int N_IN  = 9;
  localparam int N_HID = 3;
  localparam int CNT_W = $clog2(N_IN);
  localparam int HID_W = $clog2(N_HID);

  typedef enum logic [1:0] {
    S_LOAD,
    S_ACT,
    S_OUT,
    S_DONE
  } state_t;

  // Full-width signed product, rescaled, low WIDTH bits kept.
  function automatic logic signed [WIDTH-1:0] mulq(
    input logic signed [WIDTH-1:0] a,
    input logic signed [WIDTH-1:0] b
  );
    logic signed [2*WIDTH-1:0] p;
    p = (2*WIDTH)'(a) * (2*WIDTH)'(b);
    return WIDTH'(p >>> FRAC);
  endfunction

  // LSB of w(i->j) inside the flat hidden-weight bus.
  function automatic int w2_lsb(input int i, input int j);
    return (i * N_HID + j) * WIDTH;
  endfunction

  // LSB of element j inside a flat per-neuron bus.
  function automatic int vec_lsb(input int j);
    return j * WIDTH;
  endfunction

endpackage

// File: rtl/disc_stream_scorer_if.sv
// Pixel-in / score-out valid-ready bundle.
// slave = scorer side, master = producer/consumer side.
interface disc_stream_scorer_if;
  import disc_stream_scorer_pkg::*;

  logic                    pix_valid;
  logic                    pix_ready;
  logic signed [WIDTH-1:0] pix_data;
  logic                    score_valid;
  logic                    score_ready;
  logic signed [WIDTH-1:0] score;

  modport slave (
    input  pix_valid, pix_data, score_ready,
    output pix_ready, score_valid, score
  );

  modport master (
    output pix_valid, pix_data, score_ready,
    input  pix_ready, score_valid, score
  );

endinterface

// File: rtl/disc_stream_scorer_fxp_mac.sv
// Fixed-point multiply-accumulate: o_sum = i_acc + mulq(i_a, i_b).
// Sum wraps modulo 2^WIDTH.
module disc_stream_scorer_fxp_mac
  import disc_stream_scorer_pkg::*;
(
  input  logic signed [WIDTH-1:0] i_a,
  input  logic signed [WIDTH-1:0] i_b,
  input  logic signed [WIDTH-1:0] i_acc,
  output logic signed [WIDTH-1:0] o_sum
);

  assign o_sum = i_acc + mulq(i_a, i_b);

endmodule

// File: rtl/disc_stream_scorer.sv
// Time-multiplexed 9-3-1 scorer: pixels stream in, hidden
// layer accumulates per pixel, MAC #0 is reused for the output.
module disc_stream_scorer
  import disc_stream_scorer_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clr,
  disc_stream_scorer_if.slave         io,
  input  logic [N_IN*N_HID*WIDTH-1:0] wd2,
  input  logic [N_HID*WIDTH-1:0]      wd3,
  input  logic [N_HID*WIDTH-1:0]      bd2,
  input  logic [WIDTH-1:0]            bd3,
  output logic                        busy
);

  state_t                  r_state;
  state_t                  w_next;
  logic [CNT_W-1:0]        r_cnt;
  logic signed [WIDTH-1:0] r_h [N_HID];
  logic signed [WIDTH-1:0] r_acc;
  logic signed [WIDTH-1:0] r_score;

  logic signed [WIDTH-1:0] w_w2 [N_IN][N_HID];
  logic signed [WIDTH-1:0] w_w3 [N_HID];
  logic signed [WIDTH-1:0] w_b2 [N_HID];
  logic signed [WIDTH-1:0] w_a [N_HID];
  logic signed [WIDTH-1:0] w_b [N_HID];
  logic signed [WIDTH-1:0] w_c [N_HID];
  logic signed [WIDTH-1:0] w_mac [N_HID];

  logic w_pix_ready;
  logic w_score_valid;
  logic w_pix_hs;
  logic w_last_pix;
  logic w_last_out;

  for (genvar i = 0; i < N_IN; i++) begin : g_w2i
    for (genvar j = 0; j < N_HID; j++) begin : g_w2j
      assign w_w2[i][j] = wd2[w2_lsb(i, j) +: WIDTH];
    end
  end

  for (genvar j = 0; j < N_HID; j++) begin : g_vec
    assign w_w3[j] = wd3[vec_lsb(j) +: WIDTH];
    assign w_b2[j] = bd2[vec_lsb(j) +: WIDTH];
    disc_stream_scorer_fxp_mac u_mac (
      .i_a   (w_a[j]),
      .i_b   (w_b[j]),
      .i_acc (w_c[j]),
      .o_sum (w_mac[j])
    );
  end

  assign w_pix_hs   = (r_state == S_LOAD) & io.pix_valid;
  assign w_last_pix = (r_cnt == CNT_W'(N_IN - 1));
  assign w_last_out = (r_cnt == CNT_W'(N_HID - 1));

  // MAC operand select: hidden layer in LOAD, MAC #0 for output in OUT.
  always_comb begin
    for (int j = 0; j < N_HID; j++) begin
      w_a[j] = io.pix_data;
      w_b[j] = w_w2[r_cnt][j];
      w_c[j] = (r_cnt == '0) ? w_b2[j] : r_h[j];
    end
    if (r_state == S_OUT) begin
      w_a[0] = r_h[r_cnt[HID_W-1:0]];
      w_b[0] = w_w3[r_cnt[HID_W-1:0]];
      w_c[0] = r_acc;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_LOAD;
    else     r_state <= w_next;
  end

  // Next state and handshake outputs; clr overrides everything.
  always_comb begin
    w_next        = r_state;
    w_pix_ready   = 1'b0;
    w_score_valid = 1'b0;
    unique case (r_state)
      S_LOAD: begin
        w_pix_ready = ~rst;
        if (io.pix_valid && w_last_pix) w_next = S_ACT;
      end
      S_ACT: w_next = S_OUT;
      S_OUT: if (w_last_out) w_next = S_DONE;
      S_DONE: begin
        w_score_valid = 1'b1;
        if (io.score_ready) w_next = S_LOAD;
      end
      default: w_next = S_LOAD;
    endcase
    if (clr) w_next = S_LOAD;
  end

  // Datapath: accumulate, ReLU, output MAC, capture score.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_acc   <= '0;
      r_score <= '0;
      for (int j = 0; j < N_HID; j++) r_h[j] <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else begin
      unique case (r_state)
        S_LOAD: if (w_pix_hs) begin
          for (int j = 0; j < N_HID; j++) r_h[j] <= w_mac[j];
          r_cnt <= w_last_pix ? '0 : r_cnt + 1'b1;
        end
        S_ACT: begin
          for (int j = 0; j < N_HID; j++)
            if (r_h[j][WIDTH-1]) r_h[j] <= '0;
          r_acc <= bd3;
        end
        S_OUT: begin
          r_acc <= w_mac[0];
          if (w_last_out) begin
            r_score <= w_mac[0];
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign io.pix_ready   = w_pix_ready;
  assign io.score_valid = w_score_valid;
  assign io.score       = r_score;
  assign busy = !((r_state == S_LOAD) && (r_cnt == '0));

endmodule

// File: tb/tb_disc_stream_scorer.sv
// Scoreboard bench for disc_stream_scorer: directed frames
// plus randomized frames against a behavioural network model.
module tb_disc_stream_scorer;
  import disc_stream_scorer_pkg::*;

  localparam int ONE = 32'h0001_0000;

  logic clk = 1'b0;
  logic rst;
  logic clr;
  logic busy;
  logic [N_IN*N_HID*WIDTH-1:0] wd2;
  logic [N_HID*WIDTH-1:0]      wd3;
  logic [N_HID*WIDTH-1:0]      bd2;
  logic [WIDTH-1:0]            bd3;

  always #5 clk = ~clk;

  disc_stream_scorer_if bus ();

  disc_stream_scorer dut (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .io   (bus),
    .wd2  (wd2),
    .wd3  (wd3),
    .bd2  (bd2),
    .bd3  (bd3),
    .busy (busy)
  );

  int w2 [N_IN][N_HID];
  int w3 [N_HID];
  int b2 [N_HID];
  int b3;

  always_comb begin
    wd2 = '0;
    wd3 = '0;
    bd2 = '0;
    for (int i = 0; i < N_IN; i++)
      for (int j = 0; j < N_HID; j++)
        wd2[(i*N_HID+j)*WIDTH +: WIDTH] = w2[i][j];
    for (int j = 0; j < N_HID; j++) begin
      wd3[j*WIDTH +: WIDTH] = w3[j];
      bd2[j*WIDTH +: WIDTH] = b2[j];
    end
    bd3 = b3;
  end

  typedef struct {
    int score;
    int t;
  } exp_t;

  exp_t sb [$];
  int   rise_q [$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   hs_t = 0;
  bit   rnd_sr = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (rnd_sr) bus.score_ready = 1'($urandom_range(1, 0));
  end

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int mulq_m(input int a, input int b);
    longint p;
    p = longint'(a) * longint'(b);
    return int'(p >>> FRAC);
  endfunction

  // Network as written on paper: dense, ReLU, dense.
  function automatic int model(input int px [N_IN]);
    int h [N_HID];
    int acc;
    for (int j = 0; j < N_HID; j++) begin
      h[j] = b2[j];
      for (int i = 0; i < N_IN; i++)
        h[j] += mulq_m(px[i], w2[i][j]);
      if (h[j] < 0) h[j] = 0;
    end
    acc = b3;
    for (int j = 0; j < N_HID; j++)
      acc += mulq_m(h[j], w3[j]);
    return acc;
  endfunction

  // Monitor: latency on score_valid rise, stability, value on take.
  logic        prev_v = 1'b0;
  logic [31:0] prev_s = '0;
  always @(negedge clk) begin
    if (bus.score_valid && !prev_v) begin
      chk("score_expected", 32'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
        chk("latency", cyc - sb[0].t, 5);
        rise_q.push_back(cyc);
      end
    end
    if (bus.score_valid && prev_v)
      chk("score_stable", bus.score, prev_s);
    if (bus.score_valid && bus.score_ready) begin
      chk("score_pending", 32'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
        chk("score", bus.score, sb[0].score);
        void'(sb.pop_front());
      end
    end
    prev_v = bus.score_valid;
    prev_s = bus.score;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input int a, input int b,
                         input int c, input int d);
    for (int i = 0; i < N_IN; i++)
      for (int j = 0; j < N_HID; j++) w2[i][j] = a;
    for (int j = 0; j < N_HID; j++) begin
      w3[j] = b;
      b2[j] = c;
    end
    b3 = d;
  endtask

  task automatic wait_hs(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 400 && !ok; k++) begin
      @(negedge clk);
      if (bus.pix_ready) begin
        ok   = 1'b1;
        hs_t = cyc;
      end
    end
    chk("pix_handshake", 32'(ok), 1);
  endtask

  task automatic send_frame(input int px [N_IN], input int n,
                            input int gmax, input int exp_s);
    bit ok;
    for (int i = 0; i < n; i++) begin
      int g;
      g = (gmax > 0) ? int'($urandom_range(gmax, 0)) : 0;
      if (g > 0) begin
        bus.pix_valid = 1'b0;
        repeat (g) step();
      end
      bus.pix_valid = 1'b1;
      bus.pix_data  = px[i];
      wait_hs(ok);
      if (!ok) begin
        bus.pix_valid = 1'b0;
        step();
        return;
      end
      if (i == N_IN - 1) sb.push_back('{score: exp_s, t: hs_t});
      step();
    end
    bus.pix_valid = 1'b0;
    if (n == N_IN) begin
      @(negedge clk);
      chk("ready_after_frame", 32'(bus.pix_ready), 0);
      step();
    end
  endtask

  task automatic wait_empty();
    bit done;
    done = 1'b0;
    for (int k = 0; k < 3000 && !done; k++) begin
      @(negedge clk);
      done = (sb.size() == 0) && !bus.score_valid;
    end
    chk("drain", 32'(done), 1);
    step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int  ones [N_IN];
    int  px [N_IN];
    bit  seen;
    for (int i = 0; i < N_IN; i++) ones[i] = ONE;
    rst = 1'b1;
    clr = 1'b0;
    bus.pix_valid   = 1'b0;
    bus.pix_data    = '0;
    bus.score_ready = 1'b1;
    set_cfg(ONE, ONE, 0, 0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_pix_ready", 32'(bus.pix_ready), 0);
    chk("rst_score_valid", 32'(bus.score_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_score", bus.score, 0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("idle_pix_ready", 32'(bus.pix_ready), 1);
    chk("idle_busy", 32'(busy), 0);
    step();

    send_frame(ones, N_IN, 0, 32'h001B_0000);
    wait_empty();

    set_cfg(-ONE, ONE, 0, 32'h0000_8000);
    send_frame(ones, N_IN, 0, 32'h0000_8000);
    wait_empty();

    set_cfg(ONE, ONE, 0, 0);
    repeat (3) begin
      send_frame(ones, N_IN, 5, 32'h001B_0000);
      wait_empty();
    end

    bus.score_ready = 1'b0;
    send_frame(ones, N_IN, 0, 32'h001B_0000);
    seen = 1'b0;
    for (int k = 0; k < 50 && !seen; k++) begin
      @(negedge clk);
      seen = bus.score_valid;
    end
    chk("stall_valid_seen", 32'(seen), 1);
    repeat (10) begin
      step();
      @(negedge clk);
      chk("stall_valid", 32'(bus.score_valid), 1);
      chk("stall_pix_ready", 32'(bus.pix_ready), 0);
      chk("stall_score", bus.score, 32'h001B_0000);
    end
    step();
    bus.score_ready = 1'b1;
    @(negedge clk);
    step();
    @(negedge clk);
    chk("release_pix_ready", 32'(bus.pix_ready), 1);
    chk("release_valid", 32'(bus.score_valid), 0);
    step();
    wait_empty();

    send_frame(ones, 4, 0, 0);
    rst = 1'b1;
    #1;
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_pix_ready", 32'(bus.pix_ready), 0);
    chk("midrst_score", bus.score, 0);
    step();
    step();
    rst = 1'b0;
    send_frame(ones, N_IN, 0, 32'h001B_0000);
    wait_empty();

    send_frame(ones, 4, 0, 0);
    clr = 1'b1;
    bus.pix_valid = 1'b1;
    bus.pix_data  = ONE;
    step();
    clr = 1'b0;
    bus.pix_valid = 1'b0;
    @(negedge clk);
    chk("clr_busy", 32'(busy), 0);
    step();
    send_frame(ones, N_IN, 0, 32'h001B_0000);
    wait_empty();

    set_cfg(ONE, ONE, 0, 0);
    b2[0] = 32'h7FFF_0000;
    send_frame(ones, N_IN, 0, 32'h0012_0000);
    wait_empty();
    rise_q.delete();
    repeat (3) send_frame(ones, N_IN, 0, 32'h0012_0000);
    wait_empty();
    chk("b2b_count", rise_q.size(), 3);
    if (rise_q.size() == 3) begin
      chk("b2b_period0", rise_q[1] - rise_q[0], 14);
      chk("b2b_period1", rise_q[2] - rise_q[1], 14);
    end

    rnd_sr = 1'b1;
    for (int f = 0; f < 25; f++) begin
      for (int i = 0; i < N_IN; i++) begin
        for (int j = 0; j < N_HID; j++)
          w2[i][j] = int'($urandom_range(32'h3FFFF, 0)) - 32'h20000;
        px[i] = int'($urandom_range(32'h3FFFF, 0)) - 32'h20000;
      end
      for (int j = 0; j < N_HID; j++) begin
        w3[j] = int'($urandom_range(32'h3FFFF, 0)) - 32'h20000;
        if ($urandom_range(3, 0) == 0) b2[j] = int'($urandom());
        else b2[j] = int'($urandom_range(32'h3FFFF, 0)) - 32'h20000;
      end
      b3 = int'($urandom_range(32'h3FFFF, 0)) - 32'h20000;
      send_frame(px, N_IN, 3, model(px));
      wait_empty();
    end
    rnd_sr = 1'b0;
    bus.score_ready = 1'b1;
    step();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
